// File: rtl/hfifo_led_drain.sv
// rtl/hfifo_led_drain.sv - pops hfifo entries one at a time and holds each on the LEDs for DWELL cycles
//
// Ports:
//   SYSTEM_CLOCK  in   single clock, rising edge
//   reset         in   synchronous, active-high
//   rdy           in   FIFO holds at least one entry
//   fifo_dout     in   FIFO read data, valid the cycle after pop
//   freeze        in   pauses draining and the dwell countdown
//   pop           out  one-cycle FIFO read strobe (high only in POP)
//   leds          out  currently displayed value
//   busy          out  high in POP, CAPTURE and HOLD
//   shown_count   out  values displayed since reset, wraps at 256

module hfifo_led_drain #(
    parameter int WIDTH = 4,
    parameter int DWELL = 100000000,
    parameter int CNT_W = 28
) (
    input  logic             SYSTEM_CLOCK,
    input  logic             reset,
    input  logic             rdy,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             freeze,
    output logic             pop,
    output logic [WIDTH-1:0] leds,
    output logic             busy,
    output logic [7:0]       shown_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP     = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Loaded in CAPTURE so that HOLD lasts exactly DWELL cycles (DWELL-1 down to 0).
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    state_t           state;
    logic [CNT_W-1:0] dwell_cnt;

    // pop and busy are registered alongside the state so each is a clean
    // function of the state being entered.
    always_ff @(posedge SYSTEM_CLOCK) begin
        if (reset) begin
            state       <= IDLE;
            pop         <= 1'b0;
            busy        <= 1'b0;
            leds        <= '0;
            shown_count <= 8'd0;
            dwell_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rdy && !freeze) begin
                        state <= POP;
                        pop   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                POP: begin
                    state <= CAPTURE;
                    pop   <= 1'b0;
                end

                // The entry is already popped, so freeze and rdy do not matter here.
                CAPTURE: begin
                    leds        <= fifo_dout;
                    shown_count <= shown_count + 8'd1;
                    dwell_cnt   <= RELOAD;
                    state       <= HOLD;
                end

                HOLD: begin
                    if (!freeze) begin
                        if (dwell_cnt != '0) begin
                            dwell_cnt <= dwell_cnt - CNT_W'(1);
                        end else if (rdy) begin
                            // Straight to the next entry: no IDLE bubble.
                            state <= POP;
                            pop   <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    pop   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hfifo_led_drain.sv
// tb/tb_hfifo_led_drain.sv - randomized bench for hfifo_led_drain against a cycle-timeline reference model

module tb_hfifo_led_drain;

    localparam int WIDTH = 4;
    localparam int DWELL = 4;
    localparam int CNT_W = 4;

    logic             SYSTEM_CLOCK;
    logic             reset;
    logic             rdy;
    logic [WIDTH-1:0] fifo_dout;
    logic             freeze;
    logic             pop;
    logic [WIDTH-1:0] leds;
    logic             busy;
    logic [7:0]       shown_count;

    hfifo_led_drain #(
        .WIDTH(WIDTH),
        .DWELL(DWELL),
        .CNT_W(CNT_W)
    ) dut (
        .SYSTEM_CLOCK(SYSTEM_CLOCK),
        .reset       (reset),
        .rdy         (rdy),
        .fifo_dout   (fifo_dout),
        .freeze      (freeze),
        .pop         (pop),
        .leds        (leds),
        .busy        (busy),
        .shown_count (shown_count)
    );

    initial SYSTEM_CLOCK = 1'b0;
    always #5 SYSTEM_CLOCK = ~SYSTEM_CLOCK;

    // FIFO contents seen by the block; rdy is simply "queue not empty".
    logic [WIDTH-1:0] q[$];

    // Stimulus knobs set by the directed sequence.
    logic stim_reset;
    logic stim_freeze;

    // Reference model: a timeline of cycle numbers.
    // last_pop  = cycle in which pop was (expected) high
    // hold_end  = last cycle of the dwell window for the current entry
    int               k;
    int               last_pop;
    int               hold_end;
    logic             rdy_p, frz_p, rst_p;
    logic             exp_pop;
    logic             exp_busy;
    logic [WIDTH-1:0] pend_val;
    logic [WIDTH-1:0] exp_leds;
    logic [7:0]       exp_cnt;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, got, exp);
        end
    endtask

    // Apply inputs for the current cycle, advance to the middle of the next
    // cycle, update the model and compare all outputs.
    task automatic step();
        reset  = stim_reset;
        freeze = stim_freeze;
        rdy    = (q.size() != 0);
        rdy_p  = rdy;
        frz_p  = freeze;
        rst_p  = reset;
        // A frozen cycle inside the dwell window pushes the window end out by one.
        if (!reset && freeze && k >= last_pop + 2 && k <= hold_end)
            hold_end++;

        @(negedge SYSTEM_CLOCK);
        k++;

        exp_pop = 1'b0;
        if (rst_p) begin
            last_pop = -100;
            hold_end = -100;
            exp_leds = '0;
            exp_cnt  = 8'd0;
        end else begin
            if (k - 1 == hold_end)
                exp_pop = rdy_p;
            else if (k - 1 > hold_end)
                exp_pop = rdy_p && !frz_p;
            if (k == last_pop + 2) begin
                exp_leds = pend_val;
                exp_cnt  = exp_cnt + 8'd1;
            end
            if (exp_pop) begin
                last_pop = k;
                hold_end = k + 1 + DWELL;
            end
        end
        exp_busy = (k >= last_pop) && (k <= hold_end);

        chk("pop",         8'(pop),         8'(exp_pop));
        chk("busy",        8'(busy),        8'(exp_busy));
        chk("leds",        8'(leds),        8'(exp_leds));
        chk("shown_count", shown_count,     exp_cnt);

        // FIFO responds to the pop: data valid from the following cycle.
        if (exp_pop && q.size() != 0) begin
            pend_val  = q.pop_front();
            fifo_dout = pend_val;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the model is a given number of cycles past the last pop.
    task automatic wait_after_pop(input int offs, input string tag);
        for (int i = 0; i < 60 && k != last_pop + offs; i++) step();
        chk(tag, 8'(k - last_pop), 8'(offs));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        k           = 0;
        last_pop    = -100;
        hold_end    = -100;
        pend_val    = '0;
        exp_leds    = '0;
        exp_cnt     = 8'd0;
        rdy_p       = 1'b0;
        frz_p       = 1'b0;
        rst_p       = 1'b1;
        reset       = 1'b1;
        rdy         = 1'b0;
        freeze      = 1'b0;
        fifo_dout   = '0;
        stim_reset  = 1'b1;
        stim_freeze = 1'b0;

        // Reset for 3 cycles, then idle with an empty FIFO.
        run(3);
        stim_reset = 1'b0;
        run(6);

        // Single entry.
        q.push_back(4'hA);
        run(12);
        chk("single_count", shown_count, 8'd1);
        chk("single_leds", 8'(leds), 8'hA);

        // Continuous stream 1..4.
        q.push_back(4'h1);
        q.push_back(4'h2);
        q.push_back(4'h3);
        q.push_back(4'h4);
        run(30);
        chk("stream_count", shown_count, 8'd5);

        // Freeze for 10 cycles in mid-dwell.
        q.push_back(4'h5);
        wait_after_pop(3, "reach_hold_freeze");
        stim_freeze = 1'b1;
        run(10);
        stim_freeze = 1'b0;
        run(15);

        // Freeze while idle with data available: no pop until release.
        stim_freeze = 1'b1;
        q.push_back(4'h9);
        run(10);
        stim_freeze = 1'b0;
        run(12);

        // Reset while holding 7.
        q.push_back(4'h7);
        wait_after_pop(3, "reach_hold_reset");
        chk("pre_reset_leds", 8'(leds), 8'h7);
        stim_reset = 1'b1;
        step();
        stim_reset = 1'b0;
        run(8);

        // 257 random entries with random gaps and occasional freezes: counter wraps.
        for (int n = 0; n < 257; n++) begin
            q.push_back(WIDTH'($urandom_range(0, 15)));
            for (int g = $urandom_range(0, 8); g > 0; g--) begin
                stim_freeze = ($urandom_range(0, 31) == 0);
                step();
            end
        end
        stim_freeze = 1'b0;
        for (int i = 0; i < 4000 && (q.size() != 0 || k <= hold_end + 1); i++) step();
        chk("drain_done", 8'(q.size()), 8'd0);
        chk("wrap_count", shown_count, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
